// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed 7-segment display.
// Latency: WIDTH+1 enabled edges from accepted start to done/bcd_out; seg/dig_sel are combinational.
// Backpressure: start is ignored while busy; ena=0 freezes all state and blanks the display.
module count_bcd_display #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCR = 4 * DIGITS;
  localparam int SW  = SCR + WIDTH;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [SCR-1:0]    bcd_q, bcd_d;
  logic              done_q, done_d;
  logic [PW-1:0]     psc_q, psc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     sh_adj;
  logic [SW-1:0]     sh_step;
  logic [DIGITS-1:0] blank;
  logic [3:0]        cur_dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to each scratch digit >= 5, then shift left.
  always_comb begin
    sh_adj = sh_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (sh_q[WIDTH + 4*k +: 4] >= 4'd5)
        sh_adj[WIDTH + 4*k +: 4] = sh_q[WIDTH + 4*k +: 4] + 4'd3;
    end
    sh_step = {sh_adj[SW-2:0], 1'b0};
  end

  // Conversion FSM next state; nothing advances while ena is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CONV;
            cnt_d   = '0;
            sh_d    = {{SCR{1'b0}}, bin_in};
          end
        end
        S_CONV: begin
          sh_d  = sh_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            bcd_d   = sh_step[SW-1 -: SCR];
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Conversion state registers; reset aborts any conversion and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Scan prescaler and digit index next state; both hold while ena is low.
  always_comb begin
    psc_d = psc_q;
    idx_d = idx_q;
    if (ena) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      idx_q <= '0;
    end else begin
      psc_q <= psc_d;
      idx_q <= idx_d;
    end
  end

  // Leading-zero mask: digit k>0 is blank when it and every higher digit is zero.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero  = hi_zero && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && (k != 0) && hi_zero;
    end
  end

  // Display drive from the registered result and current scan position.
  always_comb begin
    cur_dig = bcd_q[{idx_q, 2'b00} +: 4];
    dig_sel = '0;
    seg     = 7'h00;
    if (ena) begin
      dig_sel = DIGITS'(1) << idx_q;
      seg     = blank[idx_q] ? 7'h00 : seg7(cur_dig);
    end
  end

  assign busy    = (state_q == S_CONV);
  assign done    = done_q & ena;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed self-checking bench for count_bcd_display (WIDTH=10, DIGITS=4, SCAN_DIV=4).
// Inputs driven and outputs sampled on the falling clock edge.
// Each comparison is an immediate assertion counting errors.
module tb_count_bcd_display;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [9:0]  bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int checks = 0;
  int errors = 0;

  count_bcd_display #(
    .WIDTH(10), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .bcd_out(bcd_out), .seg(seg), .dig_sel(dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance until done is seen, bounded; returns number of falling edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Advance until the scan has just wrapped from digit 3 to digit 0 (prescaler at 0).
  task automatic sync_scan(input string tag);
    logic [3:0] prev;
    int n;
    n = 0;
    prev = dig_sel;
    @(negedge clk);
    while (!(prev == 4'b1000 && dig_sel == 4'b0001) && n < 40) begin
      prev = dig_sel;
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, (n < 40)}, 32'd1);
  endtask

  task automatic convert(input logic [9:0] v, input string tag);
    int n;
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(n);
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    bin_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_dig_sel", dig_sel, 4'b0001);
    chk("rst_seg", seg, 7'h3F);
    rst_n = 1'b1;

    // Full-scale conversion: busy for 10 samples, done on the 11th
    bin_in = 10'd1023;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("fs_busy", busy, 1);
      chk("fs_no_done", done, 0);
      @(negedge clk);
    end
    chk("fs_busy_clear", busy, 0);
    chk("fs_done", done, 1);
    chk("fs_bcd", bcd_out, 16'h1023);
    @(negedge clk);
    chk("fs_done_pulse", done, 0);
    chk("fs_bcd_hold", bcd_out, 16'h1023);

    // Reset in the middle of a conversion
    bin_in = 10'd999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bcd", bcd_out, 16'h0000);
    chk("mid_rst_dig_sel", dig_sel, 4'b0001);
    chk("mid_rst_seg", seg, 7'h3F);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero with leading-zero blanking
    convert(10'd0, "zero_done");
    chk("zero_bcd", bcd_out, 16'h0000);
    sync_scan("zero_sync");
    chk("zero_d0_sel", dig_sel, 4'b0001);
    chk("zero_d0_seg", seg, 7'h3F);
    repeat (4) @(negedge clk);
    chk("zero_d1_sel", dig_sel, 4'b0010);
    chk("zero_d1_seg", seg, 7'h00);
    repeat (4) @(negedge clk);
    chk("zero_d2_sel", dig_sel, 4'b0100);
    chk("zero_d2_seg", seg, 7'h00);
    repeat (4) @(negedge clk);
    chk("zero_d3_sel", dig_sel, 4'b1000);
    chk("zero_d3_seg", seg, 7'h00);

    // Start collision: a request during busy is dropped
    bin_in = 10'd507;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (2) @(negedge clk);
    bin_in = 10'd999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(n);
    chk("coll_done", done, 1);
    chk("coll_bcd", bcd_out, 16'h0507);
    // Start in the done cycle is accepted
    bin_in = 10'd999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("coll_restart_busy", busy, 1);
    wait_done(n);
    chk("coll2_done", done, 1);
    chk("coll2_bcd", bcd_out, 16'h0999);

    // Scan sequence on 0507
    convert(10'd507, "scan_conv_done");
    sync_scan("scan_sync");
    chk("scan_d0_sel", dig_sel, 4'b0001);
    chk("scan_d0_seg", seg, 7'h07);
    repeat (3) @(negedge clk);
    chk("scan_d0_hold", dig_sel, 4'b0001);
    @(negedge clk);
    chk("scan_d1_sel", dig_sel, 4'b0010);
    chk("scan_d1_seg", seg, 7'h3F);
    repeat (4) @(negedge clk);
    chk("scan_d2_sel", dig_sel, 4'b0100);
    chk("scan_d2_seg", seg, 7'h6D);
    repeat (4) @(negedge clk);
    chk("scan_d3_sel", dig_sel, 4'b1000);
    chk("scan_d3_seg", seg, 7'h00);
    repeat (4) @(negedge clk);
    chk("scan_wrap_sel", dig_sel, 4'b0001);

    // Pause at iteration 4 of a conversion of 1000
    bin_in = 10'd1000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n = 1;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    ena = 1'b0;
    #1;
    chk("pause_dig_sel", dig_sel, 4'b0000);
    chk("pause_seg", seg, 7'h00);
    for (int i = 0; i < 5; i++) begin
      chk("pause_no_done", done, 0);
      chk("pause_busy_hold", busy, 1);
      @(negedge clk);
      n++;
    end
    ena = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("pause_done", done, 1);
    chk("pause_latency", n, 16);
    chk("pause_bcd", bcd_out, 16'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
